bignum_limb_ram: RTL and testbench
==================================

# bignum_limb_ram

Parametrised operand store for the Paillier datapath. Holds `SLOTS` big-number operands of `K` bits each as `K/W` limbs of `W` bits in one `single_port_ram`. Each operand is written as a limb stream and read back as a limb stream, LSB-first or MSB-first. Sits between the host/key loader and the modular multiply/exponentiation engines, replacing ad-hoc per-operand RAM instances (n, g, r, u, …) with one arbitrated store.

## Interface
- `K`, 2048, operand width in bits
- `W`, 64, limb width; K must be a multiple of W
- `SLOTS`, 4, number of operand slots
- `FILENAME`, "none", RAM init file passed to `single_port_ram`
- `clk` in 1: sole clock
- `rst_n` in 1: synchronous, active-low reset
- `wr_start` in 1: begin loading slot `wr_slot`
- `wr_slot` in $clog2(SLOTS): target slot, sampled with `wr_start`
- `wr_busy` out 1: write burst in progress
- `s_valid` in 1: write limb valid
- `s_ready` out 1: write limb accepted when `s_valid & s_ready`
- `s_data` in W: write limb
- `wr_done` out 1: one-cycle pulse after the last limb is written
- `rd_start` in 1: begin streaming slot `rd_slot`
- `rd_slot` in $clog2(SLOTS): source slot, sampled with `rd_start`
- `rd_msb_first` in 1: 1 streams limbs from LIMBS-1 down to 0; sampled with `rd_start`
- `rd_busy` out 1: read burst in progress
- `m_valid` out 1: read limb valid
- `m_ready` in 1: consumer accepts limb
- `m_data` out W: read limb
- `m_last` out 1: qualifies the final limb of the burst

## Operation
- Derived values: LIMBS = K/W; ADDR_W = $clog2(SLOTS*LIMBS). RAM address = slot*LIMBS + limb. RAM depth is SLOTS*LIMBS.
- Write FSM `W_IDLE`→`W_BURST`→`W_IDLE`:
  - `wr_start` in `W_IDLE` latches the slot, sets limb counter to 0, and raises `wr_busy`.
  - Each accepted beat writes limb `cnt`, then increments `cnt`.
  - The beat with cnt = LIMBS-1 returns the FSM to idle: `wr_busy` falls and `wr_done` pulses in the following cycle.
- Read FSM `R_IDLE`→`R_BURST`→`R_IDLE`:
  - `rd_start` latches the slot and direction; the issue counter starts at 0 (LSB-first) or LIMBS-1 (MSB-first).
  - An issue is a RAM read. An issue is allowed when all of the following hold: `rd_busy`; issued < LIMBS; occupancy + inflight − pop < 2; the port is granted.
  - RAM data enters a 2-entry output FIFO one cycle after issue.
  - `m_valid` = FIFO not empty. `m_last` is tagged on the LIMBS-th issued limb.
  - `rd_busy` clears on the `m_last` handshake.
- Port arbitration:
  - Write beat pending = `wr_busy & s_valid`.
  - When a write beat is pending and a read issue is possible in the same cycle, the grant goes to `prio`. `prio` toggles after each contended grant; its reset value is write.
  - Without contention the single requester is granted.
  - `s_ready` = `wr_busy` & write granted.
- `wr_start` while `wr_busy` and `rd_start` while `rd_busy` are ignored.
- Read and write of the same slot concurrently: no interlock. A limb returns the value in RAM at its issue cycle.
- Reset, in any state:
  - Both FSMs go to idle and the FIFO empties.
  - `wr_busy`, `rd_busy`, `s_ready`, `m_valid`, `m_last` and `wr_done` are all 0.
  - `m_data` is don't-care.
  - RAM contents are retained.

## Timing
- Write: 1 limb/cycle with `s_valid` high and no contention. The burst takes LIMBS cycles. `wr_done` fires at cycle t+LIMBS+1 for `wr_start` at t with a continuous stream.
- Read: `rd_start` at t gives first issue at t+1 and `m_valid` at t+2. With `m_ready` held high, throughput is 1 limb/cycle and the burst ends at t+LIMBS+1.
- Backpressure: `m_data`/`m_last` hold stable while `m_valid & !m_ready`. The FIFO never overflows.
- Under sustained contention each stream gets every other cycle.

## Structure
- Package `bignum_mem_pkg`: LIMBS/ADDR_W helper functions, write-FSM enum, read-FSM enum, arbitration priority enum.
- Sub-module: existing `single_port_ram` (WIDTH_DATA=W, DEPTH=SLOTS*LIMBS, FILENAME); 1-cycle registered read.
- The 2-entry output FIFO is inline logic; no separate module.

## Test plan
- Use K=256, W=64, SLOTS=4 (LIMBS=4) for all scenarios.
- Write slot 2 with 0x11,0x22,0x33,0x44, continuous valid → `wr_done` pulse 5 cycles after `wr_start`. Read slot 2 LSB-first with `m_ready`=1 → 0x11,0x22,0x33,0x44, `m_last` on 0x44, `m_valid` first at start+2.
- Same slot read with `rd_msb_first`=1 → 0x44,0x33,0x22,0x11; `m_last` on 0x11.
- Read with `m_ready` toggling 1,0,0,1,… → no lost or duplicated limbs; `m_data` stable during stalls.
- Concurrent write of slot 0 and read of slot 1 → grants alternate, `s_ready` high every other cycle, both bursts complete with correct data.
- Assert `rst_n`=0 mid-read after 2 limbs → next cycle all outputs 0; new read of slot 2 returns intact data.
- `wr_start` re-asserted during a burst → ignored; slot and counter are unchanged.

Source files
------------

// File: rtl/bignum_mem_pkg.sv
// Shared types and sizing helpers for the big-number limb store.
// The FSM state and arbitration priority encodings live here.
package bignum_mem_pkg;

    localparam int FIFO_DEPTH = 2;

    function automatic int calc_limbs(input int k, input int w);
        return k / w;
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int calc_addr_w(input int slots, input int limbs);
        return calc_idx_w(slots * limbs);
    endfunction

    typedef enum logic {
        W_IDLE,
        W_BURST
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_t;

    typedef enum logic {
        PRIO_WR,
        PRIO_RD
    } prio_t;

endpackage

// File: rtl/single_port_ram.sv
// Single-port block RAM with one-cycle registered read.
// A write cycle leaves the read register untouched.
module single_port_ram #(
    parameter int WIDTH_DATA = 64,
    parameter int DEPTH      = 16,
    parameter     FILENAME   = "none",
    parameter int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [WIDTH_DATA-1:0] din,
    output logic [WIDTH_DATA-1:0] dout
);

    logic [WIDTH_DATA-1:0] mem [DEPTH];
    logic [WIDTH_DATA-1:0] dout_reg;

    // Preloaded contents come from the device's memory-initialisation flow.
    if (FILENAME != "none") begin : g_preload
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout_reg <= mem[addr];
            end
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/bignum_limb_ram.sv
// Arbitrated limb-stream store for big-number operands: one shared RAM port,
// a write stream in and a read stream out through a 2-entry output FIFO.
module bignum_limb_ram
    import bignum_mem_pkg::*;
#(
    parameter int K        = 2048,
    parameter int W        = 64,
    parameter int SLOTS    = 4,
    parameter     FILENAME = "none"
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_start,
    input  logic [$clog2(SLOTS)-1:0] wr_slot,
    output logic                     wr_busy,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [W-1:0]             s_data,
    output logic                     wr_done,
    input  logic                     rd_start,
    input  logic [$clog2(SLOTS)-1:0] rd_slot,
    input  logic                     rd_msb_first,
    output logic                     rd_busy,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [W-1:0]             m_data,
    output logic                     m_last
);

    localparam int LIMBS  = calc_limbs(K, W);
    localparam int DEPTH  = SLOTS * LIMBS;
    localparam int ADDR_W = calc_addr_w(SLOTS, LIMBS);
    localparam int SLOT_W = $clog2(SLOTS);
    localparam int CNT_W  = calc_idx_w(LIMBS);
    localparam int ISS_W  = $clog2(LIMBS + 1);

    localparam logic [CNT_W-1:0] LAST_LIMB  = CNT_W'(LIMBS - 1);
    localparam logic [ISS_W-1:0] ISS_LIMBS  = ISS_W'(LIMBS);
    localparam logic [ISS_W-1:0] ISS_FINAL  = ISS_W'(LIMBS - 1);

    // Write side state
    wr_state_t         wr_state_reg, wr_state_next;
    logic [SLOT_W-1:0] wr_slot_reg, wr_slot_next;
    logic [CNT_W-1:0]  wr_cnt_reg, wr_cnt_next;
    logic              wr_done_reg, wr_done_next;

    // Read side state
    rd_state_t         rd_state_reg, rd_state_next;
    logic [SLOT_W-1:0] rd_slot_reg, rd_slot_next;
    logic              rd_msb_reg, rd_msb_next;
    logic [CNT_W-1:0]  rd_idx_reg, rd_idx_next;
    logic [ISS_W-1:0]  rd_issued_reg, rd_issued_next;
    logic              inflight_reg, inflight_next;
    logic              inflight_last_reg, inflight_last_next;

    // Output FIFO bookkeeping
    logic       fifo_rd_ptr_reg, fifo_rd_ptr_next;
    logic       fifo_wr_ptr_reg, fifo_wr_ptr_next;
    logic [1:0] fifo_cnt_reg, fifo_cnt_next;
    logic [W-1:0] fifo_data [FIFO_DEPTH];
    logic         fifo_last [FIFO_DEPTH];

    prio_t prio_reg, prio_next;

    logic              wr_req, rd_req, contended;
    logic              wr_grant, rd_grant;
    logic              fifo_empty, pop, push, pop_fifo;
    logic [2:0]        occ_sum;
    logic              head_last;
    logic [W-1:0]      head_data;
    logic [ADDR_W-1:0] wr_addr, rd_addr, ram_addr;
    logic              ram_en, ram_we;
    logic [W-1:0]      ram_dout;

    assign wr_busy = (wr_state_reg == W_BURST);
    assign rd_busy = (rd_state_reg == R_BURST);
    assign wr_done = wr_done_reg;

    assign fifo_empty = (fifo_cnt_reg == 2'd0);
    // A limb leaving the RAM is presented in its arrival cycle, so it counts
    // as FIFO content before it is actually stored.
    assign m_valid    = !fifo_empty || inflight_reg;
    assign head_data  = fifo_empty ? ram_dout : fifo_data[fifo_rd_ptr_reg];
    assign head_last  = fifo_empty ? inflight_last_reg : fifo_last[fifo_rd_ptr_reg];
    assign m_data     = head_data;
    assign m_last     = m_valid && head_last;

    assign pop      = m_valid && m_ready;
    assign pop_fifo = pop && !fifo_empty;
    assign push     = inflight_reg && !(fifo_empty && pop);
    assign occ_sum  = {1'b0, fifo_cnt_reg} + {2'b00, inflight_reg};

    assign wr_req    = wr_busy && s_valid;
    assign rd_req    = rd_busy && (rd_issued_reg < ISS_LIMBS)
                       && (occ_sum < (3'd2 + {2'b00, pop}));
    assign contended = wr_req && rd_req;
    assign wr_grant  = wr_req && (!rd_req || (prio_reg == PRIO_WR));
    assign rd_grant  = rd_req && !wr_grant;
    assign s_ready   = wr_grant;

    assign wr_addr  = ADDR_W'(wr_slot_reg) * ADDR_W'(LIMBS) + ADDR_W'(wr_cnt_reg);
    assign rd_addr  = ADDR_W'(rd_slot_reg) * ADDR_W'(LIMBS) + ADDR_W'(rd_idx_reg);
    assign ram_en   = wr_grant || rd_grant;
    assign ram_we   = wr_grant;
    assign ram_addr = wr_grant ? wr_addr : rd_addr;

    single_port_ram #(
        .WIDTH_DATA (W),
        .DEPTH      (DEPTH),
        .FILENAME   (FILENAME)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (s_data),
        .dout (ram_dout)
    );

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
        logic [W-1:0] data_reg;
        logic         last_reg;

        always_ff @(posedge clk) begin
            if (push && (fifo_wr_ptr_reg == 1'(gi))) begin
                data_reg <= ram_dout;
                last_reg <= inflight_last_reg;
            end
        end

        assign fifo_data[gi] = data_reg;
        assign fifo_last[gi] = last_reg;
    end

    always_comb begin
        wr_state_next = wr_state_reg;
        wr_slot_next  = wr_slot_reg;
        wr_cnt_next   = wr_cnt_reg;
        wr_done_next  = 1'b0;
        case (wr_state_reg)
            W_IDLE: begin
                if (wr_start) begin
                    wr_state_next = W_BURST;
                    wr_slot_next  = wr_slot;
                    wr_cnt_next   = '0;
                end
            end
            W_BURST: begin
                if (wr_grant) begin
                    wr_cnt_next = wr_cnt_reg + 1'b1;
                    if (wr_cnt_reg == LAST_LIMB) begin
                        wr_state_next = W_IDLE;
                        wr_done_next  = 1'b1;
                    end
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_next      = rd_state_reg;
        rd_slot_next       = rd_slot_reg;
        rd_msb_next        = rd_msb_reg;
        rd_idx_next        = rd_idx_reg;
        rd_issued_next     = rd_issued_reg;
        inflight_next      = rd_grant;
        inflight_last_next = rd_grant && (rd_issued_reg == ISS_FINAL);
        case (rd_state_reg)
            R_IDLE: begin
                if (rd_start) begin
                    rd_state_next  = R_BURST;
                    rd_slot_next   = rd_slot;
                    rd_msb_next    = rd_msb_first;
                    rd_idx_next    = rd_msb_first ? LAST_LIMB : '0;
                    rd_issued_next = '0;
                end
            end
            R_BURST: begin
                if (rd_grant) begin
                    rd_idx_next    = rd_msb_reg ? (rd_idx_reg - 1'b1) : (rd_idx_reg + 1'b1);
                    rd_issued_next = rd_issued_reg + 1'b1;
                end
                if (pop && head_last) begin
                    rd_state_next = R_IDLE;
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_ptr_next = fifo_rd_ptr_reg ^ pop_fifo;
        fifo_wr_ptr_next = fifo_wr_ptr_reg ^ push;
        fifo_cnt_next    = fifo_cnt_reg + 2'(push) - 2'(pop_fifo);
        prio_next        = prio_reg;
        if (contended) begin
            prio_next = (prio_reg == PRIO_WR) ? PRIO_RD : PRIO_WR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state_reg      <= W_IDLE;
            wr_slot_reg       <= '0;
            wr_cnt_reg        <= '0;
            wr_done_reg       <= 1'b0;
            rd_state_reg      <= R_IDLE;
            rd_slot_reg       <= '0;
            rd_msb_reg        <= 1'b0;
            rd_idx_reg        <= '0;
            rd_issued_reg     <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            fifo_rd_ptr_reg   <= 1'b0;
            fifo_wr_ptr_reg   <= 1'b0;
            fifo_cnt_reg      <= 2'd0;
            prio_reg          <= PRIO_WR;
        end else begin
            wr_state_reg      <= wr_state_next;
            wr_slot_reg       <= wr_slot_next;
            wr_cnt_reg        <= wr_cnt_next;
            wr_done_reg       <= wr_done_next;
            rd_state_reg      <= rd_state_next;
            rd_slot_reg       <= rd_slot_next;
            rd_msb_reg        <= rd_msb_next;
            rd_idx_reg        <= rd_idx_next;
            rd_issued_reg     <= rd_issued_next;
            inflight_reg      <= inflight_next;
            inflight_last_reg <= inflight_last_next;
            fifo_rd_ptr_reg   <= fifo_rd_ptr_next;
            fifo_wr_ptr_reg   <= fifo_wr_ptr_next;
            fifo_cnt_reg      <= fifo_cnt_next;
            prio_reg          <= prio_next;
        end
    end

endmodule

// File: tb/tb_bignum_limb_ram.sv
// Directed and randomized bench for bignum_limb_ram; operands are tracked in
// a per-slot limb array and expected streams are built from it.
module tb_bignum_limb_ram;

    localparam int K     = 256;
    localparam int W     = 64;
    localparam int SLOTS = 4;
    localparam int LIMBS = K / W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_start = 1'b0;
    logic [1:0]   wr_slot = '0;
    logic         wr_busy;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_data = '0;
    logic         wr_done;
    logic         rd_start = 1'b0;
    logic [1:0]   rd_slot = '0;
    logic         rd_msb_first = 1'b0;
    logic         rd_busy;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic         m_last;

    always #5 clk = ~clk;

    bignum_limb_ram #(
        .K(K), .W(W), .SLOTS(SLOTS), .FILENAME("none")
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_start(wr_start), .wr_slot(wr_slot), .wr_busy(wr_busy),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .wr_done(wr_done),
        .rd_start(rd_start), .rd_slot(rd_slot), .rd_msb_first(rd_msb_first),
        .rd_busy(rd_busy), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    logic [W-1:0] ref_mem [SLOTS][LIMBS];
    logic [W-1:0] wdata [LIMBS];
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_wr_busy"}, W'(wr_busy), '0);
        check({tag, "_rd_busy"}, W'(rd_busy), '0);
        check({tag, "_s_ready"}, W'(s_ready), '0);
        check({tag, "_m_valid"}, W'(m_valid), '0);
        check({tag, "_m_last"},  W'(m_last),  '0);
        check({tag, "_wr_done"}, W'(wr_done), '0);
    endtask

    // Writes wdata[] into a slot; gaps randomizes s_valid, inject re-fires
    // wr_start at another slot mid-burst.
    task automatic write_burst(input int slot, input bit gaps, input bit inject);
        int cnt = 0;
        int cyc = 1;
        int done_cyc = -1;
        int last_beat = -1;
        wr_start = 1'b1;
        wr_slot  = 2'(slot);
        s_valid  = 1'b0;
        tick();
        wr_start = 1'b0;
        while (done_cyc < 0 && cyc < 60) begin
            s_valid = (cnt < LIMBS) && (!gaps || $urandom_range(0, 1) == 1);
            s_data  = (cnt < LIMBS) ? wdata[cnt] : '0;
            if (inject && cnt == 2) begin
                wr_start = 1'b1;
                wr_slot  = 2'(slot ^ 1);
            end else begin
                wr_start = 1'b0;
            end
            settle();
            if (cnt < LIMBS) begin
                check("wr_s_ready", W'(s_ready), W'(s_valid));
                check("wr_busy_hold", W'(wr_busy), 1);
                check("wr_done_early", W'(wr_done), 0);
            end
            if (wr_done) begin
                done_cyc = cyc;
                check("wr_done_after_last", W'(cyc), W'(last_beat + 1));
            end
            if (s_valid && s_ready) begin
                ref_mem[slot][cnt] = s_data;
                last_beat = cyc;
                cnt++;
            end
            tick();
            cyc++;
        end
        wr_start = 1'b0;
        s_valid  = 1'b0;
        check("wr_done_seen", W'(done_cyc >= 0), 1);
        if (!gaps) check("wr_done_cycle", W'(done_cyc), W'(LIMBS + 1));
        settle();
        check("wr_busy_after", W'(wr_busy), 0);
        $display("write slot %0d gaps=%0d inject=%0d done at cycle %0d", slot, gaps, inject, done_cyc);
    endtask

    // mode 0: m_ready high, 1: pattern 1,0,0 repeating, 2: random.
    // abort_after > 0 resets the DUT once that many limbs have been taken.
    task automatic read_burst(input int slot, input bit msb, input int mode, input int abort_after);
        logic [W-1:0] exp_q[$];
        logic [W-1:0] held_data = '0;
        logic         held_last = 1'b0;
        bit           stalled = 1'b0;
        int pops = 0;
        int first = -1;
        int last_cyc = -1;
        int cyc = 1;
        for (int i = 0; i < LIMBS; i++) exp_q.push_back(ref_mem[slot][msb ? LIMBS - 1 - i : i]);
        rd_start     = 1'b1;
        rd_slot      = 2'(slot);
        rd_msb_first = msb;
        m_ready      = 1'b0;
        tick();
        rd_start     = 1'b0;
        rd_slot      = 2'($urandom);
        rd_msb_first = 1'($urandom);
        while (last_cyc < 0 && cyc < 60) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((cyc - 1) % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            settle();
            if (stalled) begin
                check("stall_valid", W'(m_valid), 1);
                check("stall_data", m_data, held_data);
                check("stall_last", W'(m_last), W'(held_last));
            end
            if (m_valid) begin
                if (first < 0) first = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_limb", W'(m_valid), 0);
                end else begin
                    check("rd_data", m_data, exp_q[0]);
                    check("rd_last", W'(m_last), W'(exp_q.size() == 1));
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        pops++;
                        if (m_last) last_cyc = cyc;
                    end
                end
            end
            stalled   = m_valid && !m_ready;
            held_data = m_data;
            held_last = m_last;
            if (abort_after > 0 && pops == abort_after) begin
                tick();
                m_ready = 1'b0;
                rst_n   = 1'b0;
                tick();
                rst_n = 1'b1;
                settle();
                check_quiet("mid_read_reset");
                $display("read slot %0d aborted by reset after %0d limbs", slot, pops);
                return;
            end
            tick();
            cyc++;
        end
        check("rd_last_seen", W'(last_cyc >= 0), 1);
        if (mode == 0) begin
            check("rd_first_valid_cycle", W'(first), 2);
            check("rd_end_cycle", W'(last_cyc), W'(LIMBS + 1));
        end
        m_ready = 1'b0;
        settle();
        check("rd_busy_after", W'(rd_busy), 0);
        check("m_valid_after", W'(m_valid), 0);
        $display("read slot %0d msb=%0d mode=%0d first=%0d last=%0d", slot, msb, mode, first, last_cyc);
    endtask

    initial begin
        logic [W-1:0] cexp[$];
        int wcnt;
        int cyc;
        bit wdone;
        bit rdone;

        // Reset state
        rst_n = 1'b0;
        s_valid = 1'b1;
        repeat (3) tick();
        settle();
        check_quiet("reset");
        s_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        $display("reset state checked");

        // Directed write of slot 2, then LSB-first, MSB-first and throttled reads
        wdata[0] = 64'h11; wdata[1] = 64'h22; wdata[2] = 64'h33; wdata[3] = 64'h44;
        write_burst(2, 1'b0, 1'b0);
        read_burst(2, 1'b0, 0, 0);
        read_burst(2, 1'b1, 0, 0);
        read_burst(2, 1'b0, 1, 0);
        read_burst(2, 1'b1, 1, 0);

        // Slot 1 gets random data with gaps, then concurrent write slot 0 / read slot 1
        for (int i = 0; i < LIMBS; i++) wdata[i] = {$urandom, $urandom};
        write_burst(1, 1'b1, 1'b0);
        for (int i = 0; i < LIMBS; i++) wdata[i] = {$urandom, $urandom};
        for (int i = 0; i < LIMBS; i++) cexp.push_back(ref_mem[1][i]);
        wr_start = 1'b1; wr_slot = 2'd0;
        rd_start = 1'b1; rd_slot = 2'd1; rd_msb_first = 1'b0;
        tick();
        wr_start = 1'b0; rd_start = 1'b0;
        wcnt = 0; cyc = 1; wdone = 1'b0; rdone = 1'b0;
        while (!(wdone && rdone) && cyc < 60) begin
            s_valid = (wcnt < LIMBS);
            s_data  = (wcnt < LIMBS) ? wdata[wcnt] : '0;
            m_ready = 1'b1;
            settle();
            if (cyc <= 2 * LIMBS - 1) check("alt_s_ready", W'(s_ready), W'(cyc % 2));
            if (s_valid && s_ready) begin
                ref_mem[0][wcnt] = s_data;
                wcnt++;
            end
            if (wr_done) wdone = 1'b1;
            if (m_valid) begin
                if (cexp.size() == 0) begin
                    check("conc_extra_limb", W'(m_valid), 0);
                end else begin
                    check("conc_rd_data", m_data, cexp[0]);
                    check("conc_rd_last", W'(m_last), W'(cexp.size() == 1));
                    void'(cexp.pop_front());
                    if (m_last) rdone = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        check("conc_both_done", W'(wdone && rdone), 1);
        $display("concurrent write slot 0 / read slot 1 finished at cycle %0d", cyc);
        read_burst(0, 1'b0, 2, 0);
        read_burst(1, 1'b1, 2, 0);

        // Reset in the middle of a read; RAM contents survive
        read_burst(2, 1'b0, 0, 2);
        tick();
        read_burst(2, 1'b0, 0, 0);

        // wr_start during a burst is ignored
        for (int i = 0; i < LIMBS; i++) wdata[i] = {$urandom, $urandom};
        write_burst(3, 1'b0, 1'b1);
        read_burst(3, 1'b0, 0, 0);
        read_burst(2, 1'b1, 0, 0);

        // Random round trips
        for (int r = 0; r < 4; r++) begin
            int slot;
            slot = $urandom_range(0, SLOTS - 1);
            for (int i = 0; i < LIMBS; i++) wdata[i] = {$urandom, $urandom};
            write_burst(slot, 1'b1, 1'b0);
            read_burst(slot, 1'($urandom), 2, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
